// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: two-requester round-robin arbiter in front of the
// register-file write port. Requester 0 is the ALU, requester 1 the load unit.
// One request is accepted per cycle. The accepted write is presented one cycle
// later with a single-cycle wrEn. Writes to R0 and illegal part-select modes
// are accepted but suppressed. An illegal mode also pulses badPpp.
// Optional feature: define RF_WB_CONFLICT_CNT_EN to add the saturating
// conflictCnt output.
module rf_wb_arbiter #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [0:ADDR_WIDTH-1] req0_addr,
    input  logic [0:DATA_WIDTH-1] req0_data,
    input  logic [0:2]            req0_ppp,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [0:ADDR_WIDTH-1] req1_addr,
    input  logic [0:DATA_WIDTH-1] req1_data,
    input  logic [0:2]            req1_ppp,
    output logic                  wrEn,
    output logic [0:ADDR_WIDTH-1] wrAddr,
    output logic [0:DATA_WIDTH-1] dataIn,
    output logic [0:2]            ppp,
    output logic                  badPpp
`ifdef RF_WB_CONFLICT_CNT_EN
    ,
    output logic [0:15]           conflictCnt
`endif
);

    // Round-robin pointer: records which requester won most recently.
    typedef enum logic {
        LAST_REQ0 = 1'b0,
        LAST_REQ1 = 1'b1
    } last_e;

    last_e                 r_last;
    last_e                 w_last_next;

    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_accept;
    logic [0:ADDR_WIDTH-1] w_sel_addr;
    logic [0:DATA_WIDTH-1] w_sel_data;
    logic [0:2]            w_sel_ppp;
    logic                  w_sel_bad;
    logic                  w_sel_r0;

    logic                  r_wrEn;
    logic                  r_badPpp;
    logic [0:ADDR_WIDTH-1] r_wrAddr;
    logic [0:DATA_WIDTH-1] r_dataIn;
    logic [0:2]            r_ppp;

    // Grant decision: a lone valid wins; on conflict the requester not granted last wins.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!reset) begin
            if (req0_valid && req1_valid) begin
                w_gnt0 = (r_last == LAST_REQ1);
                w_gnt1 = (r_last == LAST_REQ0);
            end else begin
                w_gnt0 = req0_valid;
                w_gnt1 = req1_valid;
            end
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign w_accept   = w_gnt0 | w_gnt1;

    // Payload select for the granted requester.
    always_comb begin
        w_sel_addr = req0_addr;
        w_sel_data = req0_data;
        w_sel_ppp  = req0_ppp;
        if (w_gnt1) begin
            w_sel_addr = req1_addr;
            w_sel_data = req1_data;
            w_sel_ppp  = req1_ppp;
        end
    end

    assign w_sel_bad = (w_sel_ppp > 3'd4);
    assign w_sel_r0  = (w_sel_addr == '0);

    // Pointer next-state: moves only when a grant is made.
    always_comb begin
        w_last_next = r_last;
        if (w_gnt0) begin
            w_last_next = LAST_REQ0;
        end else if (w_gnt1) begin
            w_last_next = LAST_REQ1;
        end
    end

    // Pointer register; reset so that requester 0 wins the first conflict.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= LAST_REQ1;
        end else begin
            r_last <= w_last_next;
        end
    end

    // Write-port stage. The payload loads on every grant, including suppressed
    // ones, and holds otherwise. Reset drops any in-flight write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrEn   <= 1'b0;
            r_badPpp <= 1'b0;
            r_wrAddr <= '0;
            r_dataIn <= '0;
            r_ppp    <= '0;
        end else begin
            r_wrEn   <= w_accept && !w_sel_r0 && !w_sel_bad;
            r_badPpp <= w_accept && w_sel_bad;
            if (w_accept) begin
                r_wrAddr <= w_sel_addr;
                r_dataIn <= w_sel_data;
                r_ppp    <= w_sel_ppp;
            end
        end
    end

    assign wrEn   = r_wrEn;
    assign badPpp = r_badPpp;
    assign wrAddr = r_wrAddr;
    assign dataIn = r_dataIn;
    assign ppp    = r_ppp;

`ifdef RF_WB_CONFLICT_CNT_EN
    logic [0:15] r_conflictCnt;

    // Saturating count of cycles in which both requesters were valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_conflictCnt <= '0;
        end else if (req0_valid && req1_valid && (r_conflictCnt != '1)) begin
            r_conflictCnt <= r_conflictCnt + 16'd1;
        end
    end

    assign conflictCnt = r_conflictCnt;
`endif

endmodule
